// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// No logic here; state encoding and data width only.
// Imported by the arbiter top and its priority picker.
package ram_arbiter_pkg;

  localparam int DATA_W = 32;

  // Two-bit encoding: one access phase and one response phase per RAM cycle pair.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/ram_arbiter_picker.sv
// Round-robin priority picker: first set request at or after ptr, with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module ram_arbiter_picker #(
  parameter int NREQ  = 3,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int j;

  // Scan NREQ positions starting at ptr; the first hit wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NREQ requesters.
// Latency: req seen in IDLE -> ACCESS next cycle -> ack/rdata the cycle after; 1 access per 2 cycles.
// Backpressure: requesters hold req until done; burst capped at MAX_BURST, then re-arbitration.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0]     req_wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            ack,
  output logic [DATA_W-1:0]          rdata,
  output logic [ADDR_WIDTH-1:0]      ram_addr,
  output logic [DATA_W-1:0]          ram_din,
  output logic                       ram_we,
  output logic                       ram_rd,
  input  logic [DATA_W-1:0]          ram_dout
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  state_e             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic [IDX_W-1:0]   own_q, own_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic [IDX_W-1:0]      ptr_nxt;
  logic [IDX_W-1:0]      pick_ptr;
  logic [NREQ-1:0]       pick_onehot;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [DATA_W-1:0]     own_wdata;
  logic                  own_we;

  // Pointer just past the current owner; in RESP the re-pick must already see it.
  assign ptr_nxt  = (own_q == IDX_W'(NREQ - 1)) ? '0 : own_q + IDX_W'(1);
  assign pick_ptr = (state_q == S_RESP) ? ptr_nxt : ptr_q;

  ram_arbiter_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req    (req),
    .ptr    (pick_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign own_addr  = req_addr[int'(own_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign own_wdata = req_wdata[int'(own_q)*DATA_W +: DATA_W];
  assign own_we    = req_we[own_q];

  // RAM strobes are decoded from state so reset drops them immediately; bus is 0 outside ACCESS.
  always_comb begin
    ram_we   = 1'b0;
    ram_rd   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (state_q == S_ACCESS) begin
      ram_we   = own_we;
      ram_rd   = ~own_we;
      ram_addr = own_addr;
      ram_din  = own_wdata;
    end
  end

  // Next-state: grant on IDLE, complete access in ACCESS, continue/re-arbitrate in RESP.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_onehot;
          own_d   = pick_idx;
          cnt_d   = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Withdrawal of req here is deliberately ignored; the access completes.
        ack_d   = gnt_q;
        if (ram_rd) rdata_d = ram_dout;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_RESP;
      end
      S_RESP: begin
        if (req[own_q] && (cnt_q < CNT_W'(MAX_BURST))) begin
          state_d = S_ACCESS;
        end else begin
          ptr_d = ptr_nxt;
          if (pick_any) begin
            gnt_d   = pick_onehot;
            own_d   = pick_idx;
            cnt_d   = '0;
            state_d = S_ACCESS;
          end else begin
            gnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; async reset aborts any in-flight access without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;

endmodule
